// File: rtl/ov7670_reg_seq.sv
// ov7670_reg_seq: walks an OV7670 register table and issues one SCCB write per entry.
// Define OV7670_SEQ_RETRY_EN to retry nacked writes up to 3 times and raise err when they run out.
module ov7670_reg_seq #(
    parameter int RST_WAIT_CYC = 100000,
    parameter int ADDR_W       = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] cnt_reg,
    input  logic [15:0]       reg_word,
    output logic              sccb_req,
    output logic [7:0]        sccb_addr,
    output logic [7:0]        sccb_data,
    input  logic              sccb_done,
    input  logic              sccb_nack,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int                WAIT_W    = (RST_WAIT_CYC > 1) ? $clog2(RST_WAIT_CYC) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RST_WAIT_CYC - 1);
    localparam logic [ADDR_W-1:0] CNT_LAST  = '1;
    localparam logic [15:0]       END_WORD  = 16'hFFFF;
    localparam logic [7:0]        COM7_ADDR = 8'h12;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT_ACK,
        RST_WAIT,
        NEXT,
        FINISH
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              launch;
    logic              com7_reset;

    // FINISH keeps busy high for one cycle while it settles, so a start there is still ignored.
    assign launch     = start && ((state == IDLE) || ((state == FINISH) && !busy));
    assign com7_reset = (sccb_addr == COM7_ADDR) && sccb_data[7];

`ifdef OV7670_SEQ_RETRY_EN
    logic [1:0] retry_cnt;
    logic       err_q;

    assign err = err_q;
`else
    logic unused_nack;

    assign err         = 1'b0;
    assign unused_nack = sccb_nack;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt_reg   <= '0;
            sccb_req  <= 1'b0;
            sccb_addr <= '0;
            sccb_data <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wait_cnt  <= '0;
`ifdef OV7670_SEQ_RETRY_EN
            retry_cnt <= '0;
            err_q     <= 1'b0;
`endif
        end else if (launch) begin
            state   <= FETCH;
            cnt_reg <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
`ifdef OV7670_SEQ_RETRY_EN
            retry_cnt <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    sccb_req <= 1'b0;
                end

                // The SCCB address/data registers double as the latched table word.
                FETCH: begin
                    if (reg_word == END_WORD) begin
                        state <= FINISH;
                    end else begin
                        sccb_addr <= reg_word[15:8];
                        sccb_data <= reg_word[7:0];
                        sccb_req  <= 1'b1;
                        state     <= ISSUE;
                    end
                end

                ISSUE: begin
                    sccb_req <= 1'b1;
                    state    <= WAIT_ACK;
                end

                WAIT_ACK: begin
                    if (sccb_done) begin
                        sccb_req <= 1'b0;
`ifdef OV7670_SEQ_RETRY_EN
                        if (sccb_nack) begin
                            if (retry_cnt == 2'd3) begin
                                err_q <= 1'b1;
                                state <= FINISH;
                            end else begin
                                retry_cnt <= retry_cnt + 2'd1;
                                state     <= ISSUE;
                            end
                        end else
`endif
                        if (com7_reset) begin
                            wait_cnt <= '0;
                            state    <= RST_WAIT;
                        end else begin
                            state <= NEXT;
                        end
                    end
                end

                // The sensor needs time to come out of a COM7 soft reset before the next write.
                RST_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state <= NEXT;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end

                NEXT: begin
`ifdef OV7670_SEQ_RETRY_EN
                    retry_cnt <= '0;
`endif
                    if (cnt_reg == CNT_LAST) begin
                        state <= FINISH;
                    end else begin
                        cnt_reg <= cnt_reg + ADDR_W'(1);
                        state   <= FETCH;
                    end
                end

                FINISH: begin
                    sccb_req <= 1'b0;
                    busy     <= 1'b0;
                    done     <= ~err;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_reg_seq.sv
// tb_ov7670_reg_seq: directed scenarios against a timeline model of the register sequencer.
// The model lays out expected outputs per cycle from the documented phase latencies.
module tb_ov7670_reg_seq;

    localparam int RST_WAIT = 10;
    localparam int AW       = 3;
    localparam int RESP_DLY = 5;
    localparam int MAXC     = 2048;
`ifdef OV7670_SEQ_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] cnt_reg;
    logic [15:0]   reg_word;
    logic          sccb_req;
    logic [7:0]    sccb_addr;
    logic [7:0]    sccb_data;
    logic          sccb_done = 1'b0;
    logic          sccb_nack = 1'b0;
    logic          busy;
    logic          done;
    logic          err;

    logic [15:0] tbl [8];
    assign reg_word = tbl[cnt_reg];

    always #5 clk = ~clk;

    ov7670_reg_seq #(.RST_WAIT_CYC(RST_WAIT), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .cnt_reg(cnt_reg), .reg_word(reg_word),
        .sccb_req(sccb_req), .sccb_addr(sccb_addr), .sccb_data(sccb_data),
        .sccb_done(sccb_done), .sccb_nack(sccb_nack), .busy(busy), .done(done), .err(err)
    );

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;
    int start_cyc = 0;
    int nack_idx = -1;
    int nack_cnt = 0;
    int nacks_given = 0;

    bit         exp_req  [MAXC];
    bit         exp_busy [MAXC];
    bit         exp_done [MAXC];
    bit         exp_err  [MAXC];
    int         exp_cnt  [MAXC];
    logic [7:0] exp_addr [MAXC];
    logic [7:0] exp_data [MAXC];

    int         req_cyc  [$];
    int         req_idx  [$];
    logic [7:0] req_addr [$];
    logic [7:0] req_data [$];
    int         sdone_q  [$];
    int         fin_q    [$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act !== expv)
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, expv);
        else
            n_pass++;
    endtask

    task automatic set_from(input int c, input int cn, input bit rq, input bit by, input bit dn, input bit er);
        for (int i = c; i < MAXC; i++) begin
            exp_cnt[i]  = cn;
            exp_req[i]  = rq;
            exp_busy[i] = by;
            exp_done[i] = dn;
            exp_err[i]  = er;
        end
    endtask

    task automatic set_req_from(input int c, input bit rq, input logic [7:0] a, input logic [7:0] d);
        for (int i = c; i < MAXC; i++) begin
            exp_req[i]  = rq;
            exp_addr[i] = a;
            exp_data[i] = d;
        end
    endtask

    // Timeline: FETCH 1 cycle, req from the next cycle until the responder's done,
    // then NEXT (or 10 wait cycles + NEXT after a COM7 reset), FINISH settles one cycle.
    task automatic predict(input int s);
        int t, r, d, n, idx, nk;
        logic [15:0] w;
        idx = 0;
        t   = s + 1;
        forever begin
            w = tbl[idx];
            set_from(t, idx, 1'b0, 1'b1, 1'b0, 1'b0);
            if (w == 16'hFFFF) begin
                set_from(t + 1, idx, 1'b0, 1'b1, 1'b0, 1'b0);
                set_from(t + 2, idx, 1'b0, 1'b0, 1'b1, 1'b0);
                return;
            end
            nk = 0;
            r  = t + 1;
            forever begin
                d = r + RESP_DLY;
                set_req_from(r, 1'b1, w[15:8], w[7:0]);
                set_req_from(d + 1, 1'b0, w[15:8], w[7:0]);
                if (RETRY_EN && idx == nack_idx && nk < nack_cnt) begin
                    nk++;
                    if (nk == 4) begin
                        set_from(d + 1, idx, 1'b0, 1'b1, 1'b0, 1'b1);
                        set_from(d + 2, idx, 1'b0, 1'b0, 1'b0, 1'b1);
                        return;
                    end
                    r = d + 2;
                end else begin
                    break;
                end
            end
            n = (w[15:8] == 8'h12 && w[7]) ? d + 1 + RST_WAIT : d + 1;
            if (idx == (1 << AW) - 1) begin
                set_from(n + 1, idx, 1'b0, 1'b1, 1'b0, 1'b0);
                set_from(n + 2, idx, 1'b0, 1'b0, 1'b1, 1'b0);
                return;
            end
            idx++;
            t = n + 1;
        end
    endtask

    task automatic model_reset(input int c);
        set_from(c + 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_req_from(c + 1, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic loadFiller();
        for (int i = 0; i < 8; i++)
            tbl[i] = 16'h2040 + 16'(i * 16'h0101);
    endtask

    task automatic applyStimulus(input int nidx, input int ncnt);
        nack_idx    = nidx;
        nack_cnt    = ncnt;
        nacks_given = 0;
        req_cyc.delete();
        req_idx.delete();
        req_addr.delete();
        req_data.delete();
        sdone_q.delete();
        fin_q.delete();
        start     = 1'b1;
        start_cyc = cyc;
        predict(cyc);
        step(1);
        start = 1'b0;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // SCCB slave stand-in: done five cycles after req rises, nacking per the current plan.
    initial begin
        int age = 0;
        forever begin
            @(posedge clk);
            #1;
            sccb_done = 1'b0;
            sccb_nack = 1'b0;
            if (sccb_req === 1'b1) begin
                age++;
                if (age == RESP_DLY + 1) begin
                    sccb_done = 1'b1;
                    if (int'(cnt_reg) == nack_idx && nacks_given < nack_cnt) begin
                        sccb_nack = 1'b1;
                        nacks_given++;
                    end
                    sdone_q.push_back(cyc);
                    age = 0;
                end
            end else begin
                age = 0;
            end
        end
    end

    initial begin
        bit prev_req = 1'b0;
        bit prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (sccb_req === 1'b1 && !prev_req) begin
                req_cyc.push_back(cyc);
                req_idx.push_back(int'(cnt_reg));
                req_addr.push_back(sccb_addr);
                req_data.push_back(sccb_data);
            end
            if (done === 1'b1 && !prev_done)
                fin_q.push_back(cyc);
            prev_req  = (sccb_req === 1'b1);
            prev_done = (done === 1'b1);
        end
    end

    initial forever begin
        @(negedge clk);
        if (cyc >= 1 && cyc < MAXC) begin
            checkOutput("sccb_req", sccb_req, exp_req[cyc]);
            checkOutput("busy", busy, exp_busy[cyc]);
            checkOutput("done", done, exp_done[cyc]);
            checkOutput("err", err, exp_err[cyc]);
            checkOutput("cnt_reg", cnt_reg, exp_cnt[cyc]);
            if (exp_req[cyc]) begin
                checkOutput("sccb_addr", sccb_addr, exp_addr[cyc]);
                checkOutput("sccb_data", sccb_data, exp_data[cyc]);
            end
        end
    end

    initial begin
        int k;
        int n2;
        int last2;
        set_from(1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_req_from(1, 1'b0, 8'h00, 8'h00);
        loadFiller();

        step(3);
        rst = 1'b0;
        checkOutput("rst_addr", sccb_addr, 8'h00);
        checkOutput("rst_data", sccb_data, 8'h00);

        $display("[TB] end-marker word at index 0");
        tbl[0] = 16'hFFFF;
        applyStimulus(-1, 0);
        step(10);
        checkOutput("ffff_no_req", req_cyc.size(), 0);
        checkOutput("ffff_done_lat", (fin_q.size() > 0) ? fin_q[0] - start_cyc : -1, 3);

        $display("[TB] COM7 reset table");
        loadFiller();
        tbl[0] = 16'h1280;
        tbl[1] = 16'h1204;
        tbl[2] = 16'hFFFF;
        applyStimulus(-1, 0);
        step(60);
        checkOutput("com7_writes", req_cyc.size(), 2);
        checkOutput("com7_w0_addr", (req_addr.size() > 0) ? req_addr[0] : 8'hxx, 8'h12);
        checkOutput("com7_w0_data", (req_data.size() > 0) ? req_data[0] : 8'hxx, 8'h80);
        checkOutput("com7_w1_addr", (req_addr.size() > 1) ? req_addr[1] : 8'hxx, 8'h12);
        checkOutput("com7_w1_data", (req_data.size() > 1) ? req_data[1] : 8'hxx, 8'h04);
        checkOutput("com7_first_req", (req_cyc.size() > 0) ? req_cyc[0] - start_cyc : -1, 2);
        checkOutput("com7_gap", (req_cyc.size() > 1 && sdone_q.size() > 0) ? req_cyc[1] - sdone_q[0] : -1, 13);
        checkOutput("com7_done", done, 1);
        checkOutput("com7_cnt_end", cnt_reg, 2);

        $display("[TB] full table, start ignored at index 5");
        loadFiller();
        applyStimulus(-1, 0);
        k = 0;
        while (cnt_reg !== 3'd5 && k < 200) begin
            step(1);
            k++;
        end
        checkOutput("reach_idx5", cnt_reg, 5);
        start = 1'b1;
        step(1);
        start = 1'b0;
        checkOutput("ign_start_busy", busy, 1);
        step(100);
        checkOutput("full_writes", req_cyc.size(), 8);
        for (int i = 0; i < 8; i++)
            checkOutput("full_idx", (req_idx.size() > i) ? req_idx[i] : -1, i);
        checkOutput("full_done", done, 1);
        checkOutput("full_cnt_end", cnt_reg, 7);
        checkOutput("full_busy_end", busy, 0);

        $display("[TB] reset during write at index 3");
        applyStimulus(-1, 0);
        k = 0;
        while (!(cnt_reg === 3'd3 && sccb_req === 1'b1) && k < 200) begin
            step(1);
            k++;
        end
        checkOutput("reach_idx3_req", {cnt_reg === 3'd3, sccb_req === 1'b1}, 2'b11);
        rst = 1'b1;
        model_reset(cyc);
        step(1);
        rst = 1'b0;
        checkOutput("rst_mid_req", sccb_req, 0);
        checkOutput("rst_mid_cnt", cnt_reg, 0);
        checkOutput("rst_mid_busy", busy, 0);
        applyStimulus(-1, 0);
        step(100);
        checkOutput("restart_idx0", (req_idx.size() > 0) ? req_idx[0] : -1, 0);
        checkOutput("restart_done", done, 1);

        $display("[TB] two nacks at index 2");
        applyStimulus(2, 2);
        step(120);
        n2 = 0;
        last2 = -1;
        for (int i = 0; i < req_idx.size(); i++) begin
            if (req_idx[i] == 2) begin
                n2++;
                last2 = i;
                checkOutput("retry_addr", req_addr[i], tbl[2][15:8]);
                checkOutput("retry_data", req_data[i], tbl[2][7:0]);
            end
        end
        checkOutput("retry_count", n2, RETRY_EN ? 3 : 1);
        checkOutput("retry_next_idx", (last2 >= 0 && req_idx.size() > last2 + 1) ? req_idx[last2 + 1] : -1, 3);
        checkOutput("retry_err", err, 0);
        checkOutput("retry_done", done, 1);

        $display("[TB] four nacks at index 2");
        applyStimulus(2, 4);
        step(120);
        checkOutput("exhaust_err", err, RETRY_EN ? 1 : 0);
        checkOutput("exhaust_done", done, RETRY_EN ? 0 : 1);
        checkOutput("exhaust_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
